hwregs_arbiter: RTL and testbench

Two-master arbiter for the 16-bit hardware-register bus (E000_0000–E000_FFFF window). It sits between the address decoder's hwregs port (master 0, CPU path) and a second master (master 1, debug/DMA bridge), and drives the single hwregs peripheral bus. Requests from both masters are buffered, granted round-robin, and issued one per cycle. Read responses, which the peripheral returns in order, are routed back to the originating master with that master's tag.

---
 rtl/hwregs_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_hwregs_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hwregs_arbiter.sv
// hwregs_arbiter: two-master round-robin arbiter for the 16-bit hwregs bus.
// Each master has a one-entry request buffer. Reads are tracked in an in-order
// {master id, tag} FIFO so responses can be steered back to their originator.

module hwregs_arb_slot (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_load,
   input  logic        i_clear,
   input  logic        i_write,
   input  logic [15:0] i_address,
   input  logic [3:0]  i_wmask,
   input  logic [31:0] i_wdata,
   input  logic [8:0]  i_tag,
   output logic        o_pend,
   output logic        o_write,
   output logic [15:0] o_address,
   output logic [3:0]  o_wmask,
   output logic [31:0] o_wdata,
   output logic [8:0]  o_tag
);
   logic        r_pend;
   logic        r_write;
   logic [15:0] r_address;
   logic [3:0]  r_wmask;
   logic [31:0] r_wdata;
   logic [8:0]  r_tag;

   // Load beats clear so a master being granted can refill in the same cycle
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pend    <= 1'b0;
         r_write   <= 1'b0;
         r_address <= '0;
         r_wmask   <= '0;
         r_wdata   <= '0;
         r_tag     <= '0;
      end else if (i_load) begin
         r_pend    <= 1'b1;
         r_write   <= i_write;
         r_address <= i_address;
         r_wmask   <= i_wmask;
         r_wdata   <= i_wdata;
         r_tag     <= i_tag;
      end else if (i_clear) begin
         r_pend    <= 1'b0;
      end
   end

   assign o_pend    = r_pend;
   assign o_write   = r_write;
   assign o_address = r_address;
   assign o_wmask   = r_wmask;
   assign o_wdata   = r_wdata;
   assign o_tag     = r_tag;
endmodule

module hwregs_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_m0_request,
   output logic        o_m0_ready,
   input  logic        i_m0_write,
   input  logic [15:0] i_m0_address,
   input  logic [3:0]  i_m0_wmask,
   input  logic [31:0] i_m0_wdata,
   input  logic [8:0]  i_m0_tag,
   output logic        o_m0_rvalid,
   output logic [31:0] o_m0_rdata,
   output logic [8:0]  o_m0_rtag,
   input  logic        i_m1_request,
   output logic        o_m1_ready,
   input  logic        i_m1_write,
   input  logic [15:0] i_m1_address,
   input  logic [3:0]  i_m1_wmask,
   input  logic [31:0] i_m1_wdata,
   input  logic [8:0]  i_m1_tag,
   output logic        o_m1_rvalid,
   output logic [31:0] o_m1_rdata,
   output logic [8:0]  o_m1_rtag,
   output logic        o_hwregs_request,
   output logic        o_hwregs_write,
   output logic [15:0] o_hwregs_address,
   output logic [3:0]  o_hwregs_wmask,
   output logic [31:0] o_hwregs_wdata,
   input  logic        i_hwregs_rvalid,
   input  logic [31:0] i_hwregs_rdata,
   output logic        o_err_unexpected
);
   localparam int AW = $clog2(MAX_OUTSTANDING);
   localparam int CW = AW + 1;

   logic [1:0]        w_req, w_in_write, w_pend, w_pwrite, w_elig, w_gnt, w_rdy;
   logic [1:0][15:0]  w_in_addr, w_paddr;
   logic [1:0][3:0]   w_in_wmask, w_pwmask;
   logic [1:0][31:0]  w_in_wdata, w_pwdata;
   logic [1:0][8:0]   w_in_tag, w_ptag;
   logic              w_gid, w_push, w_pop, w_head_id;
   logic [8:0]        w_head_tag;

   logic [CW-1:0]                    r_count;
   logic [AW-1:0]                    r_wptr, r_rptr;
   logic [MAX_OUTSTANDING-1:0]       r_fifo_id;
   logic [MAX_OUTSTANDING-1:0][8:0]  r_fifo_tag;
   logic                             r_rr, r_err;
   logic                             r_hw_req, r_hw_write;
   logic [15:0]                      r_hw_addr;
   logic [3:0]                       r_hw_wmask;
   logic [31:0]                      r_hw_wdata;
   logic [1:0]                       r_rvalid;
   logic [1:0][31:0]                 r_rdata;
   logic [1:0][8:0]                  r_rtag;

   assign w_req      = {i_m1_request, i_m0_request};
   assign w_in_write = {i_m1_write,   i_m0_write};
   assign w_in_addr  = {i_m1_address, i_m0_address};
   assign w_in_wmask = {i_m1_wmask,   i_m0_wmask};
   assign w_in_wdata = {i_m1_wdata,   i_m0_wdata};
   assign w_in_tag   = {i_m1_tag,     i_m0_tag};

   for (genvar n = 0; n < 2; n++) begin : g_slot
      hwregs_arb_slot u_slot (
         .i_clock   (i_clock),
         .i_reset   (i_reset),
         .i_load    (w_req[n] & w_rdy[n]),
         .i_clear   (w_gnt[n]),
         .i_write   (w_in_write[n]),
         .i_address (w_in_addr[n]),
         .i_wmask   (w_in_wmask[n]),
         .i_wdata   (w_in_wdata[n]),
         .i_tag     (w_in_tag[n]),
         .o_pend    (w_pend[n]),
         .o_write   (w_pwrite[n]),
         .o_address (w_paddr[n]),
         .o_wmask   (w_pwmask[n]),
         .o_wdata   (w_pwdata[n]),
         .o_tag     (w_ptag[n])
      );
      // Reads wait for a free outstanding slot; writes never do
      assign w_elig[n] = w_pend[n] & (w_pwrite[n] | (r_count < CW'(MAX_OUTSTANDING)));
   end

   // Single winner per cycle; the pointer only matters when both are eligible
   always_comb begin
      w_gnt = w_elig;
      if (&w_elig) w_gnt = r_rr ? 2'b10 : 2'b01;
   end

   assign w_gid      = w_gnt[1];
   assign w_rdy      = ~w_pend | w_gnt;
   assign w_push     = (|w_gnt) & ~w_pwrite[w_gid];
   assign w_pop      = i_hwregs_rvalid & (r_count != '0);
   assign w_head_id  = r_fifo_id[r_rptr];
   assign w_head_tag = r_fifo_tag[r_rptr];

   // Register the granted request onto the bus; idle cycles drive zeros
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_hw_req   <= 1'b0;
         r_hw_write <= 1'b0;
         r_hw_addr  <= '0;
         r_hw_wmask <= '0;
         r_hw_wdata <= '0;
         r_rr       <= 1'b0;
      end else begin
         r_hw_req   <= |w_gnt;
         r_hw_write <= (|w_gnt) & w_pwrite[w_gid];
         r_hw_addr  <= (|w_gnt) ? w_paddr[w_gid]  : '0;
         r_hw_wmask <= (|w_gnt) ? w_pwmask[w_gid] : '0;
         r_hw_wdata <= (|w_gnt) ? w_pwdata[w_gid] : '0;
         if (|w_gnt) r_rr <= ~w_gid;
      end
   end

   // In-order read tracker; power-of-two depth lets the pointers wrap naturally
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo_id[r_wptr]  <= w_gid;
            r_fifo_tag[r_wptr] <= w_ptag[w_gid];
            r_wptr             <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (i_hwregs_rvalid && r_count == '0) r_err <= 1'b1;
      end
   end

   // Steer the popped response to its master; the other master sees zeros
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_rtag   <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            r_rvalid[n] <= w_pop & (w_head_id == 1'(n));
            r_rdata[n]  <= (w_pop && w_head_id == 1'(n)) ? i_hwregs_rdata : '0;
            r_rtag[n]   <= (w_pop && w_head_id == 1'(n)) ? w_head_tag : '0;
         end
      end
   end

   assign o_m0_ready       = w_rdy[0];
   assign o_m1_ready       = w_rdy[1];
   assign o_m0_rvalid      = r_rvalid[0];
   assign o_m0_rdata       = r_rdata[0];
   assign o_m0_rtag        = r_rtag[0];
   assign o_m1_rvalid      = r_rvalid[1];
   assign o_m1_rdata       = r_rdata[1];
   assign o_m1_rtag        = r_rtag[1];
   assign o_hwregs_request = r_hw_req;
   assign o_hwregs_write   = r_hw_write;
   assign o_hwregs_address = r_hw_addr;
   assign o_hwregs_wmask   = r_hw_wmask;
   assign o_hwregs_wdata   = r_hw_wdata;
   assign o_err_unexpected = r_err;
endmodule

// File: tb/tb_hwregs_arbiter.sv
// Directed bench for hwregs_arbiter with hand-computed expectations.
module tb_hwregs_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req, m0_write, m1_req, m1_write;
   logic [15:0] m0_addr, m1_addr;
   logic [3:0]  m0_wmask, m1_wmask;
   logic [31:0] m0_wdata, m1_wdata;
   logic [8:0]  m0_tag, m1_tag;
   logic        m0_rdy, m1_rdy, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [8:0]  m0_rtag, m1_rtag;
   logic        hw_req, hw_write, hw_rvalid, err;
   logic [15:0] hw_addr;
   logic [3:0]  hw_wmask;
   logic [31:0] hw_wdata, hw_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hwregs_arbiter #(.MAX_OUTSTANDING(4)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_m0_request(m0_req), .o_m0_ready(m0_rdy), .i_m0_write(m0_write),
      .i_m0_address(m0_addr), .i_m0_wmask(m0_wmask), .i_m0_wdata(m0_wdata),
      .i_m0_tag(m0_tag), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_rtag(m0_rtag),
      .i_m1_request(m1_req), .o_m1_ready(m1_rdy), .i_m1_write(m1_write),
      .i_m1_address(m1_addr), .i_m1_wmask(m1_wmask), .i_m1_wdata(m1_wdata),
      .i_m1_tag(m1_tag), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_rtag(m1_rtag),
      .o_hwregs_request(hw_req), .o_hwregs_write(hw_write), .o_hwregs_address(hw_addr),
      .o_hwregs_wmask(hw_wmask), .o_hwregs_wdata(hw_wdata),
      .i_hwregs_rvalid(hw_rvalid), .i_hwregs_rdata(hw_rdata), .o_err_unexpected(err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      m0_req = 0; m0_write = 0; m0_addr = 0; m0_wmask = 0; m0_wdata = 0; m0_tag = 0;
      m1_req = 0; m1_write = 0; m1_addr = 0; m1_wmask = 0; m1_wdata = 0; m1_tag = 0;
      hw_rvalid = 0; hw_rdata = 0;
   endtask

   task automatic do_reset;
      idle_in();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_hwreq"}, {hw_req, hw_write, hw_addr, hw_wmask, hw_wdata}, 0);
      chk({tag, "_m0rsp"}, {m0_rvalid, m0_rdata, m0_rtag}, 0);
      chk({tag, "_m1rsp"}, {m1_rvalid, m1_rdata, m1_rtag}, 0);
      chk({tag, "_rdy"}, {m0_rdy, m1_rdy}, 2'b11);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int s0, s1, iss, lo0, lo1, mx0, mx1;
      // ---- reset state
      do_reset();
      chk_idle("rst");

      // ---- single read
      m0_req = 1; m0_write = 0; m0_addr = 16'h0010; m0_tag = 9'h05;
      step();
      idle_in();
      chk("sr_t1_req", hw_req, 0);
      step();
      chk("sr_t2_req", {hw_req, hw_write, hw_addr}, {1'b1, 1'b0, 16'h0010});
      step();
      step();
      hw_rvalid = 1; hw_rdata = 32'hDEADBEEF;
      step();
      hw_rvalid = 0;
      chk("sr_rsp", {m0_rvalid, m0_rdata, m0_rtag}, {1'b1, 32'hDEADBEEF, 9'h05});
      chk("sr_m1", m1_rvalid, 0);

      // ---- contention: both masters keep 4 writes each queued
      do_reset();
      s0 = 0; s1 = 0; iss = 0; lo0 = 0; lo1 = 0; mx0 = 0; mx1 = 0;
      for (int c = 0; c < 14; c++) begin
         if (hw_req) begin
            chk("cont_addr", hw_addr, (iss % 2 == 0) ? 16'h100 + iss / 2 : 16'h200 + iss / 2);
            iss++;
         end
         if (s0 < 4) begin lo0 = m0_rdy ? 0 : lo0 + 1; if (lo0 > mx0) mx0 = lo0; end
         if (s1 < 4) begin lo1 = m1_rdy ? 0 : lo1 + 1; if (lo1 > mx1) mx1 = lo1; end
         m0_req = (s0 < 4); m0_write = 1; m0_addr = 16'h100 + 16'(s0);
         m1_req = (s1 < 4); m1_write = 1; m1_addr = 16'h200 + 16'(s1);
         if (m0_req && m0_rdy) s0++;
         if (m1_req && m1_rdy) s1++;
         step();
      end
      idle_in();
      chk("cont_issued", iss, 8);
      chk("cont_m0_lowrun", mx0, 1);
      chk("cont_m1_lowrun", mx1, 1);

      // ---- outstanding limit: 5 reads from m1, no responses
      do_reset();
      s1 = 0; iss = 0;
      for (int c = 0; c < 8; c++) begin
         if (hw_req) iss++;
         m1_req = (s1 < 5); m1_write = 0; m1_addr = 16'h300 + 16'(s1); m1_tag = 9'h10 + 9'(s1);
         if (m1_req && m1_rdy) s1++;
         step();
      end
      idle_in();
      chk("lim_issued", iss, 4);
      chk("lim_accepted", s1, 5);
      chk("lim_blocked", {m1_rdy, hw_req}, 2'b00);
      hw_rvalid = 1; hw_rdata = 32'hA0;
      chk("lim_rdy_at_pop", m1_rdy, 0);
      step();
      hw_rvalid = 0;
      chk("lim_rsp0", {m1_rvalid, m1_rdata, m1_rtag}, {1'b1, 32'hA0, 9'h10});
      chk("lim_rdy_after", m1_rdy, 1);
      step();
      chk("lim_5th", {hw_req, hw_write, hw_addr}, {1'b1, 1'b0, 16'h0304});
      for (int i = 0; i < 4; i++) begin
         hw_rvalid = 1; hw_rdata = 32'hB0 + i;
         step();
         hw_rvalid = 0;
         chk("lim_drain", {m1_rvalid, m1_rdata, m1_rtag}, {1'b1, 32'hB0 + i, 9'h11 + 9'(i)});
      end

      // ---- ordering across masters
      do_reset();
      m0_req = 1; m0_addr = 16'h20; m0_tag = 9'd1;
      m1_req = 1; m1_addr = 16'h21; m1_tag = 9'd2;
      step();
      m1_req = 0;
      chk("ord_m0_rdy", m0_rdy, 1);
      m0_addr = 16'h22; m0_tag = 9'd3;
      step();
      m0_req = 0;
      step(); step(); step();
      hw_rvalid = 1; hw_rdata = 32'hAAAA0001;
      step();
      hw_rdata = 32'hBBBB0002;
      chk("ord_A", {m0_rvalid, m0_rdata, m0_rtag, m1_rvalid}, {1'b1, 32'hAAAA0001, 9'd1, 1'b0});
      step();
      hw_rdata = 32'hCCCC0003;
      chk("ord_B", {m1_rvalid, m1_rdata, m1_rtag, m0_rvalid, m0_rdata}, {1'b1, 32'hBBBB0002, 9'd2, 1'b0, 32'h0});
      step();
      hw_rvalid = 0;
      chk("ord_C", {m0_rvalid, m0_rdata, m0_rtag, m1_rvalid}, {1'b1, 32'hCCCC0003, 9'd3, 1'b0});

      // ---- write from m1 while FIFO is full of m0 reads
      do_reset();
      for (int i = 0; i < 4; i++) begin
         m0_req = 1; m0_write = 0; m0_addr = 16'h40 + 16'(i); m0_tag = 9'(i);
         chk("full_m0_rdy", m0_rdy, 1);
         step();
      end
      m0_req = 0;
      step(); step();
      chk("full_count", dut.r_count, 4);
      m0_req = 1; m0_write = 0; m0_addr = 16'h44; m0_tag = 9'd4;
      m1_req = 1; m1_write = 1; m1_addr = 16'h0004; m1_wmask = 4'hF; m1_wdata = 32'h12345678;
      step();
      idle_in();
      chk("full_t1", hw_req, 0);
      step();
      chk("full_wr", {hw_req, hw_write, hw_addr, hw_wmask, hw_wdata},
          {1'b1, 1'b1, 16'h0004, 4'hF, 32'h12345678});
      chk("full_count2", dut.r_count, 4);
      chk("full_m0_blk", m0_rdy, 0);

      // ---- unexpected response, then reset with reads outstanding
      do_reset();
      hw_rvalid = 1; hw_rdata = 32'h55;
      step();
      hw_rvalid = 0;
      chk("err_set", {err, m0_rvalid, m1_rvalid}, 3'b100);
      m0_req = 1; m0_addr = 16'h60; m0_tag = 9'd7;
      m1_req = 1; m1_addr = 16'h61; m1_tag = 9'd8;
      step();
      idle_in();
      step(); step();
      chk("err_outst", dut.r_count, 2);
      rst = 1;
      step();
      rst = 0;
      chk_idle("mid_rst");
      hw_rvalid = 1; hw_rdata = 32'h66;
      step();
      hw_rvalid = 0;
      chk("post_rst_err", {err, m0_rvalid, m1_rvalid}, 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
